// File: rtl/qar_arb_pkg.sv
// Shared types and constants for the QAR two-port memory arbiter.
package qar_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    // Read data returned to the requester when a hung access is aborted.
    localparam logic [31:0] ARB_ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/qar_arb_watchdog.sv
// Grant timeout counter for qar_mem_arbiter.
// Instantiated only when QAR_ARB_WATCHDOG_EN is defined.
// It counts stalled grant cycles and flags the stalled cycle on which
// the count reaches TIMEOUT_CYCLES.
module qar_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;

    // Stall counter: clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

    // The count holds the number of earlier stalled cycles, so the
    // TIMEOUT_CYCLES-th stalled cycle sees TIMEOUT_CYCLES-1.
    assign expire = en && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/qar_mem_arbiter.sv
// Two-port-to-one memory arbiter for the QAR core.
// The fetch port (i_*) and the data port (d_*) share one valid/ready memory port.
// Data wins ties from IDLE. A port whose grant completes while the other port is
// waiting hands the grant straight over.
// Optional watchdog: define QAR_ARB_WATCHDOG_EN to abort grants stalled for
// TIMEOUT_CYCLES cycles.
module qar_mem_arbiter
    import qar_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ready,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_valid,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  bus_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("qar_mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e state_q;
    arb_state_e state_d;
    logic       in_grant;
    logic       abort;
    logic       grant_done;

    assign in_grant   = (state_q != IDLE);
    assign grant_done = in_grant && (mem_ready || abort);

`ifdef QAR_ARB_WATCHDOG_EN
    logic wd_clr;
    logic wd_en;

    assign wd_en  = in_grant && !mem_ready;
    // Clearing at each completion or abort leaves the count at zero on
    // entry to every grant, including direct hand-overs between ports.
    assign wd_clr = !in_grant || grant_done;

    qar_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (abort)
    );
`else
    assign abort = 1'b0;
`endif

    assign bus_err = abort;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // On completion only the other port's valid matters: the finishing
    // port's own valid is stale in that cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (d_valid) begin
                    state_d = GNT_D;
                end else if (i_valid) begin
                    state_d = GNT_I;
                end
            end
            GNT_I: begin
                if (grant_done) begin
                    state_d = d_valid ? GNT_D : IDLE;
                end
            end
            GNT_D: begin
                if (grant_done) begin
                    state_d = i_valid ? GNT_I : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Downstream request mux and per-port completion strobes.
    always_comb begin
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        i_rdata   = mem_rdata;
        d_rdata   = mem_rdata;
        unique case (state_q)
            GNT_I: begin
                mem_valid = 1'b1;
                mem_addr  = i_addr;
                i_ready   = mem_ready || abort;
`ifdef QAR_ARB_WATCHDOG_EN
                if (abort) begin
                    i_rdata = DATA_WIDTH'(ARB_ABORT_DATA);
                end
`endif
            end
            GNT_D: begin
                mem_valid = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_ready   = mem_ready || abort;
`ifdef QAR_ARB_WATCHDOG_EN
                if (abort) begin
                    d_rdata = DATA_WIDTH'(ARB_ABORT_DATA);
                end
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qar_mem_arbiter.sv
// Directed bench for qar_mem_arbiter with a small behavioural memory slave.
// Unwritten words of the slave read as 32'h1000_0000 + word index.
module tb_qar_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_valid, d_valid, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ready, d_ready;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_valid, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    int wait_n = 0;
    bit stall  = 1'b0;
    int wcnt   = 0;
    logic [31:0] mem_arr [256];
    bit          written [256];
    logic [7:0]  widx;

    always #5 clk = ~clk;

    qar_mem_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_valid   (d_valid),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err)
    );

    // Slave: combinational ready after wait_n wait states, word-addressed store.
    assign widx = mem_addr[9:2];
    always_comb begin
        mem_ready = mem_valid && !stall && (wcnt >= wait_n);
        mem_rdata = written[widx] ? mem_arr[widx] : (32'h1000_0000 + {24'b0, widx});
    end

    always @(posedge clk) begin
        if (mem_valid && mem_ready && mem_we) begin
            mem_arr[widx] <= mem_wdata;
            written[widx] <= 1'b1;
        end
        if (!mem_valid || mem_ready) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] ia, input logic dv,
                         input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
        i_valid = iv; i_addr = ia; d_valid = dv; d_we = dwe; d_addr = da; d_wdata = dwd;
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        emv;
        logic        ewe;
        logic [31:0] eaddr;
        logic [31:0] ewd;
        logic        eir;
        logic        edr;
        logic [31:0] erd;
    } vec_t;

    function automatic vec_t mk(logic iv, logic [31:0] ia, logic dv, logic dwe,
                                logic [31:0] da, logic [31:0] dwd, logic emv, logic ewe,
                                logic [31:0] eaddr, logic [31:0] ewd, logic eir,
                                logic edr, logic [31:0] erd);
        vec_t v;
        v.iv = iv; v.ia = ia; v.dv = dv; v.dwe = dwe; v.da = da; v.dwd = dwd;
        v.emv = emv; v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd;
        v.eir = eir; v.edr = edr; v.erd = erd;
        return v;
    endfunction

    vec_t tbl [21];

    initial begin
        // One record per clock cycle, zero-wait slave.
        tbl[0]  = mk(0, 0,     0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0);
        tbl[1]  = mk(1, 'h10,  0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0);
        tbl[2]  = mk(1, 'h10,  0, 0, 0,     0,     1, 0, 'h10,  0,     1, 0, 'h1000_0004);
        tbl[3]  = mk(0, 0,     0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0);
        tbl[4]  = mk(1, 'h20,  1, 1, 'h40,  'hCAFE_F00D, 0, 0, 0, 0,   0, 0, 0);
        tbl[5]  = mk(1, 'h20,  1, 1, 'h40,  'hCAFE_F00D, 1, 1, 'h40, 'hCAFE_F00D, 0, 1, 'h1000_0010);
        tbl[6]  = mk(1, 'h20,  0, 0, 0,     0,     1, 0, 'h20,  0,     1, 0, 'h1000_0008);
        tbl[7]  = mk(0, 0,     0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0);
        tbl[8]  = mk(0, 0,     1, 0, 'h40,  0,     0, 0, 0,     0,     0, 0, 0);
        tbl[9]  = mk(0, 0,     1, 0, 'h40,  0,     1, 0, 'h40,  0,     0, 1, 'hCAFE_F00D);
        tbl[10] = mk(0, 0,     0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0);
        tbl[11] = mk(1, 'hA0,  1, 0, 'hB0,  0,     0, 0, 0,     0,     0, 0, 0);
        tbl[12] = mk(1, 'hA0,  1, 0, 'hB0,  0,     1, 0, 'hB0,  0,     0, 1, 'h1000_002C);
        tbl[13] = mk(1, 'hA0,  1, 0, 'hB4,  0,     1, 0, 'hA0,  0,     1, 0, 'h1000_0028);
        tbl[14] = mk(1, 'hA4,  1, 0, 'hB4,  0,     1, 0, 'hB4,  0,     0, 1, 'h1000_002D);
        tbl[15] = mk(1, 'hA4,  1, 0, 'hB8,  0,     1, 0, 'hA4,  0,     1, 0, 'h1000_0029);
        tbl[16] = mk(1, 'hA8,  1, 0, 'hB8,  0,     1, 0, 'hB8,  0,     0, 1, 'h1000_002E);
        tbl[17] = mk(1, 'hA8,  1, 0, 'hBC,  0,     1, 0, 'hA8,  0,     1, 0, 'h1000_002A);
        tbl[18] = mk(1, 'hAC,  1, 0, 'hBC,  0,     1, 0, 'hBC,  0,     0, 1, 'h1000_002F);
        tbl[19] = mk(1, 'hAC,  0, 0, 0,     0,     1, 0, 'hAC,  0,     1, 0, 'h1000_002B);
        tbl[20] = mk(0, 0,     0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0);

        drive(0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("reset.mem_valid", {31'b0, mem_valid}, 0);
        chk("reset.mem_addr",  mem_addr, 0);
        chk("reset.i_ready",   {31'b0, i_ready}, 0);
        chk("reset.d_ready",   {31'b0, d_ready}, 0);
        chk("reset.bus_err",   {31'b0, bus_err}, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].iv, tbl[i].ia, tbl[i].dv, tbl[i].dwe, tbl[i].da, tbl[i].dwd);
            #3;
            chk($sformatf("v%0d.mem_valid", i), {31'b0, mem_valid}, {31'b0, tbl[i].emv});
            chk($sformatf("v%0d.mem_we", i),    {31'b0, mem_we},    {31'b0, tbl[i].ewe});
            chk($sformatf("v%0d.mem_addr", i),  mem_addr,  tbl[i].eaddr);
            chk($sformatf("v%0d.mem_wdata", i), mem_wdata, tbl[i].ewd);
            chk($sformatf("v%0d.i_ready", i),   {31'b0, i_ready},   {31'b0, tbl[i].eir});
            chk($sformatf("v%0d.d_ready", i),   {31'b0, d_ready},   {31'b0, tbl[i].edr});
            chk($sformatf("v%0d.bus_err", i),   {31'b0, bus_err},   0);
            if (tbl[i].eir) chk($sformatf("v%0d.i_rdata", i), i_rdata, tbl[i].erd);
            if (tbl[i].edr) chk($sformatf("v%0d.d_rdata", i), d_rdata, tbl[i].erd);
        end

        // Three wait states: load from 0x80 holds the address for 4 grant cycles.
        wait_n = 3;
        @(posedge clk); #1 drive(0, 0, 1, 0, 'h80, 0); #3;
        chk("ws.arb_cycle.mem_valid", {31'b0, mem_valid}, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #4;
            chk($sformatf("ws%0d.mem_valid", k), {31'b0, mem_valid}, 1);
            chk($sformatf("ws%0d.mem_addr", k),  mem_addr, 'h80);
            chk($sformatf("ws%0d.d_ready", k),   {31'b0, d_ready}, (k == 3) ? 1 : 0);
            chk($sformatf("ws%0d.i_ready", k),   {31'b0, i_ready}, 0);
            if (k == 3) chk("ws.d_rdata", d_rdata, 'h1000_0020);
        end
        @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0); #3;
        chk("ws.after.mem_valid", {31'b0, mem_valid}, 0);
        chk("ws.after.d_ready",   {31'b0, d_ready}, 0);

        // Reset in the second wait state drops the access with no strobe.
        @(posedge clk); #1 drive(0, 0, 1, 0, 'h84, 0); #3;
        @(posedge clk); #4;
        chk("rst.g1.mem_valid", {31'b0, mem_valid}, 1);
        chk("rst.g1.d_ready",   {31'b0, d_ready}, 0);
        @(posedge clk); #1 rst_n = 1'b0; #1;
        chk("rst.mid.mem_valid", {31'b0, mem_valid}, 0);
        chk("rst.mid.d_ready",   {31'b0, d_ready}, 0);
        chk("rst.mid.i_ready",   {31'b0, i_ready}, 0);
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1 rst_n = 1'b1; wait_n = 0;
        @(posedge clk); #1 drive(1, 'h30, 0, 0, 0, 0); #3;
        chk("rst.post.arb.mem_valid", {31'b0, mem_valid}, 0);
        @(posedge clk); #4;
        chk("rst.post.mem_valid", {31'b0, mem_valid}, 1);
        chk("rst.post.mem_addr",  mem_addr, 'h30);
        chk("rst.post.i_ready",   {31'b0, i_ready}, 1);
        chk("rst.post.i_rdata",   i_rdata, 'h1000_000C);
        @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0); #3;
        chk("rst.post.idle.mem_valid", {31'b0, mem_valid}, 0);

`ifdef QAR_ARB_WATCHDOG_EN
        // Slave never ready: the 4th stalled cycle aborts, then the fetch is granted.
        stall = 1'b1;
        @(posedge clk); #1 drive(1, 'h14, 1, 0, 'h90, 0); #3;
        chk("wd.arb.mem_valid", {31'b0, mem_valid}, 0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #4;
            chk($sformatf("wd%0d.mem_addr", k), mem_addr, 'h90);
            chk($sformatf("wd%0d.d_ready", k),  {31'b0, d_ready}, (k == 4) ? 1 : 0);
            chk($sformatf("wd%0d.bus_err", k),  {31'b0, bus_err}, (k == 4) ? 1 : 0);
            if (k == 4) chk("wd.d_rdata", d_rdata, 32'hDEAD_BEEF);
        end
        @(posedge clk); #1 drive(1, 'h14, 0, 0, 0, 0); stall = 1'b0; #3;
        chk("wd.next.mem_valid", {31'b0, mem_valid}, 1);
        chk("wd.next.mem_addr",  mem_addr, 'h14);
        chk("wd.next.i_ready",   {31'b0, i_ready}, 1);
        chk("wd.next.bus_err",   {31'b0, bus_err}, 0);
        @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0); #3;
        chk("wd.idle.mem_valid", {31'b0, mem_valid}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
